bsg_zedboard_mmcm_drp_ctrl: RTL and testbench

BSG_ZEDBOARD_MMCM_DRP_CTRL -- requirements
Module: bsg_zedboard_mmcm_drp_ctrl

---
 rtl/bsg_zedboard_pkg.sv | 47 ++++
 rtl/bsg_zedboard_sync2.sv | 32 +++
 rtl/bsg_zedboard_mmcm_drp_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_bsg_zedboard_mmcm_drp_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_zedboard_pkg.sv
// Shared types for the Zedboard MMCM DRP reconfiguration controller.
//
// Contents:
//   drp_state_e    - controller FSM states
//   drp_entry_s    - one reconfiguration entry: {addr, mask, data, last}
//   rst_cycles_lp  - number of cycles the controller dwells in RST
//   drp_merge()    - read-modify-write merge of a DRP register
//   holds_mmcm_rst() - states in which the MMCM is held in reset
package bsg_zedboard_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    RELEASE,
    LOCK_WAIT,
    DONE
  } drp_state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;  // 1 = keep the bit currently in the DRP register
    logic [15:0] data;  // replacement bits where mask = 0
    logic        last;  // final entry of the batch
  } drp_entry_s;

  localparam int unsigned rst_cycles_lp = 4;

  // Keep the bits selected by mask from the old value, take the rest from data.
  function automatic logic [15:0] drp_merge(input logic [15:0] old_v,
                                            input logic [15:0] mask_v,
                                            input logic [15:0] data_v);
    return (old_v & mask_v) | (data_v & ~mask_v);
  endfunction

  // The MMCM stays in reset from RST through the last DRP write of the batch,
  // including the gaps spent waiting for further entries in NEXT.
  function automatic logic holds_mmcm_rst(input drp_state_e s);
    return (s == RST)     || (s == RD_REQ)  || (s == RD_WAIT) ||
           (s == WR_REQ)  || (s == WR_WAIT) || (s == NEXT);
  endfunction

endpackage

// File: rtl/bsg_zedboard_sync2.sv
// Two-flop synchronizer for a single asynchronous level (MMCM LOCKED).
//
// Ports:
//   clk_i    - destination clock
//   reset_i  - synchronous active-high reset, clears both flops
//   d_i      - asynchronous input level
//   q_o      - synchronized level, two clk_i cycles of latency
module bsg_zedboard_sync2 (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bsg_zedboard_mmcm_drp_ctrl.sv
// MMCM dynamic-reconfiguration (DRP) controller.
//
// Accepts a batch of {addr, mask, data, last} entries over a valid/ready
// handshake. The first entry puts the MMCM into reset; each entry then does
// a DRP read-modify-write of one register. After the last entry the MMCM reset
// is released and the controller waits for LOCKED, reporting completion with a
// one-cycle done pulse and an error bit (DRP or lock timeout).
//
// Ports:
//   clk_i, reset_i             - clock (also MMCM DCLK), sync active-high reset
//   cmd_v_i / cmd_ready_o      - entry handshake
//   cmd_addr_i, cmd_mask_i,
//   cmd_data_i, cmd_last_i     - entry fields (mask bit 1 = keep old bit)
//   drp_daddr_o, drp_di_o,
//   drp_den_o, drp_dwe_o,
//   drp_do_i, drp_drdy_i       - MMCM DRP port
//   mmcm_rst_o, mmcm_locked_i  - MMCM RST and asynchronous LOCKED
//   busy_o                     - high whenever not IDLE
//   done_v_o, error_o          - completion pulse and its error status
//   locked_o                   - LOCKED after a two-flop synchronizer
module bsg_zedboard_mmcm_drp_ctrl
  import bsg_zedboard_pkg::*;
#(
  parameter int unsigned lock_timeout_p = 65535,
  parameter int unsigned drdy_timeout_p = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,

  input  logic        cmd_v_i,
  output logic        cmd_ready_o,
  input  logic [6:0]  cmd_addr_i,
  input  logic [15:0] cmd_mask_i,
  input  logic [15:0] cmd_data_i,
  input  logic        cmd_last_i,

  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,

  output logic        mmcm_rst_o,
  input  logic        mmcm_locked_i,

  output logic        busy_o,
  output logic        done_v_o,
  output logic        error_o,
  output logic        locked_o
);

  // One counter serves the RST dwell, DRP timeouts and the lock timeout; it is
  // sized for the largest limit and cleared on every state change.
  localparam int unsigned max_lim_lp =
    (lock_timeout_p > drdy_timeout_p)
      ? ((lock_timeout_p > rst_cycles_lp) ? lock_timeout_p : rst_cycles_lp)
      : ((drdy_timeout_p > rst_cycles_lp) ? drdy_timeout_p : rst_cycles_lp);
  localparam int cnt_w_lp = $clog2(max_lim_lp + 1);

  localparam logic [cnt_w_lp-1:0] rst_last_lp  = cnt_w_lp'(rst_cycles_lp - 1);
  localparam logic [cnt_w_lp-1:0] drdy_lim_lp  = cnt_w_lp'(drdy_timeout_p);
  localparam logic [cnt_w_lp-1:0] lock_lim_lp  = cnt_w_lp'(lock_timeout_p);

  drp_state_e            state_q, state_d;
  drp_entry_s            entry_q, entry_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  err_q,   err_d;
  logic [cnt_w_lp-1:0]   cnt_q,   cnt_d;
  logic                  mmcm_rst_q;
  logic                  accept;
  logic                  locked_sync;

  bsg_zedboard_sync2 lock_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (mmcm_locked_i),
    .q_o     (locked_sync)
  );

  assign accept = cmd_v_i & cmd_ready_o;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      mmcm_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      // Registered from the next state so the MMCM RST pin is glitch-free.
      mmcm_rst_q <= holds_mmcm_rst(state_d);
    end
  end

  // NOTE: the entry and merged write word are pure datapath, only ever read in
  // states reached after they are loaded, so they carry no reset.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
    wdata_q <= wdata_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          entry_d = '{addr: cmd_addr_i, mask: cmd_mask_i,
                      data: cmd_data_i, last: cmd_last_i};
          state_d = RST;
        end
      end

      RST: begin
        if (cnt_q == rst_last_lp) state_d = RD_REQ;
      end

      RD_REQ: state_d = RD_WAIT;

      RD_WAIT: begin
        // drdy takes priority over a timeout reached on the same cycle.
        if (drp_drdy_i) begin
          wdata_d = drp_merge(drp_do_i, entry_q.mask, entry_q.data);
          state_d = WR_REQ;
        end else if (cnt_q == drdy_lim_lp) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end

      WR_REQ: state_d = WR_WAIT;

      WR_WAIT: begin
        if (drp_drdy_i) begin
          state_d = entry_q.last ? RELEASE : NEXT;
        end else if (cnt_q == drdy_lim_lp) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end

      NEXT: begin
        // MMCM is already in reset; go straight to the next read.
        if (accept) begin
          entry_d = '{addr: cmd_addr_i, mask: cmd_mask_i,
                      data: cmd_data_i, last: cmd_last_i};
          state_d = RD_REQ;
        end
      end

      RELEASE: state_d = LOCK_WAIT;

      LOCK_WAIT: begin
        if (locked_sync) begin
          state_d = DONE;
        end else if (cnt_q == lock_lim_lp) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Fresh count on entry to each state; saturate rather than wrap.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + cnt_w_lp'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready_o = ~reset_i & ((state_q == IDLE) | (state_q == NEXT));
    drp_den_o   = (state_q == RD_REQ) | (state_q == WR_REQ);
    drp_dwe_o   = (state_q == WR_REQ);
    drp_daddr_o = entry_q.addr;
    drp_di_o    = wdata_q;
    mmcm_rst_o  = mmcm_rst_q;
    busy_o      = (state_q != IDLE);
    done_v_o    = (state_q == DONE);
    error_o     = (state_q == DONE) & err_q;
    locked_o    = locked_sync;
  end

endmodule

// File: tb/tb_bsg_zedboard_mmcm_drp_ctrl.sv
// Directed bench for bsg_zedboard_mmcm_drp_ctrl with a behavioural DRP
// register file and MMCM lock model.
module tb_bsg_zedboard_mmcm_drp_ctrl;

  localparam int lock_to = 100;
  localparam int drdy_to = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic [6:0]  cmd_addr_i = '0;
  logic [15:0] cmd_mask_i = '0;
  logic [15:0] cmd_data_i = '0;
  logic        cmd_last_i = 1'b0;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [15:0] drp_do_i = '0;
  logic        drp_drdy_i = 1'b0;
  logic        mmcm_rst_o;
  logic        mmcm_locked_i = 1'b0;
  logic        busy_o;
  logic        done_v_o;
  logic        error_o;
  logic        locked_o;

  bsg_zedboard_mmcm_drp_ctrl #(
    .lock_timeout_p (lock_to),
    .drdy_timeout_p (drdy_to)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_mask_i    (cmd_mask_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_last_i    (cmd_last_i),
    .drp_daddr_o   (drp_daddr_o),
    .drp_di_o      (drp_di_o),
    .drp_den_o     (drp_den_o),
    .drp_dwe_o     (drp_dwe_o),
    .drp_do_i      (drp_do_i),
    .drp_drdy_i    (drp_drdy_i),
    .mmcm_rst_o    (mmcm_rst_o),
    .mmcm_locked_i (mmcm_locked_i),
    .busy_o        (busy_o),
    .done_v_o      (done_v_o),
    .error_o       (error_o),
    .locked_o      (locked_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // DRP register model: drdy arrives drp_lat cycles after the strobe.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [128];
  int          drp_lat = 2;
  bit          drp_hang = 1'b0;
  int          pend = 0;
  logic [15:0] rd_val = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [6:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  always @(posedge clk) begin
    if (drp_den_o) begin
      if (drp_dwe_o) begin
        mem[drp_daddr_o] = drp_di_o;
        wr_cnt++;
        last_wr_addr = drp_daddr_o;
        last_wr_data = drp_di_o;
      end else begin
        rd_cnt++;
        rd_val = mem[drp_daddr_o];
      end
      pend = drp_hang ? 0 : drp_lat;
    end else if (pend > 0) begin
      pend--;
    end
    #1;
    drp_drdy_i = (pend == 1);
    drp_do_i   = (pend == 1) ? rd_val : 16'hDEAD;
  end

  // ---------------------------------------------------------------------------
  // MMCM lock model: locks lock_delay cycles after RST is seen low.
  // ---------------------------------------------------------------------------
  bit lock_en = 1'b1;
  int lock_delay = 5;
  int lock_cnt = 0;

  always @(posedge clk) begin
    if (mmcm_rst_o) lock_cnt = 0;
    else if (lock_cnt < 10000) lock_cnt++;
    #1;
    mmcm_locked_i = lock_en && (lock_cnt >= lock_delay);
  end

  // ---------------------------------------------------------------------------
  // Output monitors, sampled mid-cycle.
  // ---------------------------------------------------------------------------
  int   done_cnt = 0;
  logic last_err = 1'b0;
  int   done_cyc = 0;
  int   den_cnt = 0;
  int   den_cyc = 0;
  int   rst_high = 0;
  int   rst_rise_cnt = 0;
  int   rst_rise_cyc = 0;
  int   rst_fall_cnt = 0;
  int   rst_fall_cyc = 0;
  int   first_den_cyc = -1;
  logic rst_prev = 1'b0;

  always @(negedge clk) begin
    if (done_v_o) begin
      done_cnt++;
      last_err = error_o;
      done_cyc = cyc;
    end
    if (mmcm_rst_o) rst_high++;
    if (mmcm_rst_o && !rst_prev) begin
      rst_rise_cnt++;
      rst_rise_cyc  = cyc;
      first_den_cyc = -1;
    end
    if (!mmcm_rst_o && rst_prev) begin
      rst_fall_cnt++;
      rst_fall_cyc = cyc;
    end
    if (drp_den_o) begin
      den_cnt++;
      den_cyc = cyc;
      if (first_den_cyc < 0) first_den_cyc = cyc;
    end
    rst_prev = mmcm_rst_o;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_entry(input logic [6:0] a, input logic [15:0] m,
                            input logic [15:0] d, input logic l,
                            output int waited);
    bit ok;
    cmd_addr_i = a;
    cmd_mask_i = m;
    cmd_data_i = d;
    cmd_last_i = l;
    cmd_v_i    = 1'b1;
    waited     = 0;
    ok         = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    @(posedge clk);
    #1;
    cmd_v_i = 1'b0;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_v_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected done");
    $fatal(1);
  end

  int w, rd0, wr0, done0, fall0, rise0, den0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    mem[9]  = 16'h1234;
    mem[20] = 16'hA5A5;

    // ---- Reset state ----
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, busy_o},      32'd0);
    check("rst_ready",  {31'd0, cmd_ready_o}, 32'd0);
    check("rst_mmcm",   {31'd0, mmcm_rst_o},  32'd0);
    check("rst_den",    {31'd0, drp_den_o},   32'd0);
    check("rst_done",   {31'd0, done_v_o},    32'd0);
    check("rst_locked", {31'd0, locked_o},    32'd0);
    reset_i = 1'b0;
    #1;
    check("idle_ready", {31'd0, cmd_ready_o}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("idle_locked", {31'd0, locked_o}, 32'd1);

    // ---- Single entry: 0xFFFF keep bit 12, new low bits 0x145 -> 0x1145 ----
    drp_lat = 2; lock_delay = 5;
    rd0 = rd_cnt; wr0 = wr_cnt; done0 = done_cnt; rst_high = 0;
    send_entry(7'h08, 16'h1000, 16'h0145, 1'b1, w);
    wait_done("t1_done");
    check("t1_err",        {31'd0, last_err},        32'd0);
    check("t1_reads",      rd_cnt - rd0,             32'd1);
    check("t1_writes",     wr_cnt - wr0,             32'd1);
    check("t1_wr_addr",    {25'd0, last_wr_addr},    32'h08);
    check("t1_wr_data",    {16'd0, last_wr_data},    32'h1145);
    check("t1_rst_cycles", rst_high,                 32'd10);
    check("t1_rst_to_den", first_den_cyc - rst_rise_cyc, 32'd4);
    check("t1_rel_to_done", done_cyc - rst_fall_cyc, 32'd8);
    check("t1_busy_after", {31'd0, busy_o},          32'd0);
    check("t1_rst_after",  {31'd0, mmcm_rst_o},      32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_pulses", done_cnt - done0, 32'd1);

    // ---- 3-entry batch with a 2-cycle gap before entry 2 ----
    rd0 = rd_cnt; wr0 = wr_cnt; done0 = done_cnt;
    fall0 = rst_fall_cnt; rise0 = rst_rise_cnt;
    send_entry(7'h08, 16'hFF00, 16'h00AB, 1'b0, w);
    wait_ready("t2_next1");
    check("t2_rst_in_next", {31'd0, mmcm_rst_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    send_entry(7'h09, 16'h0F0F, 16'hA0A0, 1'b0, w);
    check("t2_e2_wait", w, 32'd0);
    // Held through RD_REQ, RD_WAIT x2, WR_REQ, WR_WAIT x2 before NEXT.
    send_entry(7'h14, 16'h0000, 16'h5A5A, 1'b1, w);
    check("t2_e3_held", w, 32'd6);
    wait_done("t2_done");
    check("t2_err",      {31'd0, last_err},  32'd0);
    check("t2_reads",    rd_cnt - rd0,       32'd3);
    check("t2_writes",   wr_cnt - wr0,       32'd3);
    check("t2_mem08",    {16'd0, mem[8]},    32'h11AB);
    check("t2_mem09",    {16'd0, mem[9]},    32'hA2A4);
    check("t2_mem14",    {16'd0, mem[20]},   32'h5A5A);
    check("t2_rst_rise", rst_rise_cnt - rise0, 32'd1);
    check("t2_rst_fall", rst_fall_cnt - fall0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_done_pulses", done_cnt - done0, 32'd1);

    // ---- DRP never answers: timeout after the read strobe ----
    drp_hang = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_entry(7'h08, 16'hFFFF, 16'h0000, 1'b1, w);
    wait_done("t3_done");
    check("t3_err",       {31'd0, last_err},      32'd1);
    check("t3_reads",     rd_cnt - rd0,           32'd1);
    check("t3_writes",    wr_cnt - wr0,           32'd0);
    check("t3_den_to_rel", rst_fall_cyc - den_cyc, drdy_to + 2);
    check("t3_rst_after", {31'd0, mmcm_rst_o},    32'd0);
    check("t3_mem08",     {16'd0, mem[8]},        32'h11AB);
    drp_hang = 1'b0;

    // ---- Lock never comes: lock timeout ----
    lock_en = 1'b0; drp_lat = 1;
    wr0 = wr_cnt;
    send_entry(7'h09, 16'hFFFF, 16'h0000, 1'b1, w);
    wait_done("t4_done");
    check("t4_err",        {31'd0, last_err},      32'd1);
    check("t4_writes",     wr_cnt - wr0,           32'd1);
    check("t4_rel_to_done", done_cyc - rst_fall_cyc, lock_to + 2);
    check("t4_locked",     {31'd0, locked_o},      32'd0);
    lock_en = 1'b1;
    repeat (10) @(posedge clk);

    // ---- Reset while in WR_WAIT ----
    drp_lat = 3;
    done0 = done_cnt;
    send_entry(7'h14, 16'h0000, 16'h1234, 1'b0, w);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (drp_dwe_o) begin
          ok = 1'b1;
          break;
        end
      end
      check("t5_saw_write", {31'd0, ok}, 32'd1);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy",  {31'd0, busy_o},      32'd0);
    check("t5_mmcm",  {31'd0, mmcm_rst_o},  32'd0);
    check("t5_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("t5_den",   {31'd0, drp_den_o},   32'd0);
    reset_i = 1'b0;
    den0 = den_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done",   done_cnt - done0,       32'd0);
    check("t5_no_strobe", den_cnt - den0,         32'd0);
    check("t5_idle_rdy",  {31'd0, cmd_ready_o},   32'd1);

    // ---- Recovery: clean run after errors and reset ----
    drp_lat = 1; lock_delay = 3;
    rst_high = 0;
    send_entry(7'h09, 16'h00FF, 16'h5500, 1'b1, w);
    wait_done("t6_done");
    check("t6_err",        {31'd0, last_err}, 32'd0);
    check("t6_mem09",      {16'd0, mem[9]},   32'h55A4);
    check("t6_rst_cycles", rst_high,          32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
